// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the programmable synchronous FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;

  // Level counts 0..depth inclusive, so it needs one more code than the pointers.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Next pointer value; explicit compare so non-power-of-two depths wrap correctly.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module fifo_mem_2p #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable thresholds, flush and
// selectable standard / first-word-fall-through read behaviour.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int LVL_W      = lvl_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [LVL_W-1:0]      af_thresh,
  input  logic [LVL_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [LVL_W-1:0]      level
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full        = (level_q == DEPTH_LVL);
  assign empty       = (level_q == '0);
  assign almostfull  = (level_q >= af_thresh);
  assign almostempty = (level_q <= ae_thresh);
  assign level       = level_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = PTR_W'(ptr_wrap(32'(wr_ptr_q), FIFO_DEPTH));
      if (rd_acc) rd_ptr_d = PTR_W'(ptr_wrap(32'(rd_ptr_q), FIFO_DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem_2p #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH),
    .AW   (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc && !flush && !rst),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign data_out = rd_data;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (!flush && rd_acc) begin
          data_out_d = rd_data;
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_q <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          data_out_q <= data_out_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
